// File: rtl/axi_uart_rx_ext.sv
// UART receiver with runtime frame format (5-8 data bits, none/odd/even
// parity, 1 or 2 stop bits), 3-sample majority voting, false-start and break
// handling, per-byte error flags and an AXI-stream FIFO with overrun counting.
module axi_uart_rx_ext #(
   parameter int SIZE        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic [15:0] clkdiv,
   input  logic [1:0]  data_bits,
   input  logic [1:0]  parity_mode,
   input  logic        two_stop,
   output logic [7:0]  o_tdata,
   output logic [2:0]  o_tuser,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic [15:0] fifo_level,
   output logic [15:0] overrun_count,
   input  logic        clear_overrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
   } state_t;

   localparam logic [SIZE:0] L_DEPTH = {1'b1, {SIZE{1'b0}}};

   state_t r_state, w_state_nx;

   logic [SYNC_STAGES-1:0] r_sync;
   logic        r_rx_prev;
   logic [15:0] r_div;
   logic [2:0]  r_last;
   logic        r_par_en, r_par_odd, r_two_stop;
   logic [15:0] r_cnt;
   logic        r_s0, r_s1;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_data;
   logic        r_par_bit, r_ferr;
   logic        r_push_pend;
   logic [10:0] r_push_entry;

   logic [10:0]   r_mem [0:(1<<SIZE)-1];
   logic [SIZE-1:0] r_wr, r_rd;
   logic [SIZE:0] r_count;
   logic [15:0]   r_ovr;

   logic        w_rxs, w_fall, w_cfg_ok, w_maj, w_perr, w_brk;
   logic [15:0] w_half;
   logic        w_at_s0, w_at_s1, w_at_s2, w_bit_end;
   logic        w_start, w_frame_end, w_brk_end;
   logic        w_full, w_pop, w_push, w_drop;
   logic [10:0] w_head;

   assign w_rxs     = r_sync[SYNC_STAGES-1];
   assign w_fall    = r_rx_prev & ~w_rxs;
   assign w_cfg_ok  = (clkdiv >= 16'd4);
   assign w_half    = {1'b0, r_div[15:1]};
   assign w_at_s0   = (r_cnt == w_half - 16'd1);
   assign w_at_s1   = (r_cnt == w_half);
   assign w_at_s2   = (r_cnt == w_half + 16'd1);
   assign w_bit_end = (r_cnt == r_div);
   // The third sample is the live line value; the first two were captured earlier.
   assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
   assign w_perr    = r_par_en & (((^r_data) ^ r_par_bit) != r_par_odd);
   // r_data only ever holds the configured number of bits, so a zero test is enough.
   assign w_brk     = (r_data == 8'h00) & ~r_par_bit & ~w_maj;

   // Input synchroniser plus one extra flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync    <= '1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
         r_rx_prev <= w_rxs;
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nx;
   end

   // Next-state decode and frame-level strobes.
   always_comb begin
      w_state_nx  = r_state;
      w_start     = 1'b0;
      w_frame_end = 1'b0;
      w_brk_end   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall && w_cfg_ok) begin
               w_state_nx = S_START;
               w_start    = 1'b1;
            end
         end
         S_START: begin
            if (w_at_s2 && w_maj)  w_state_nx = S_IDLE;
            else if (w_bit_end)    w_state_nx = S_DATA;
         end
         S_DATA: begin
            if (w_bit_end && (r_bitcnt == r_last))
               w_state_nx = r_par_en ? S_PARITY : S_STOP1;
         end
         S_PARITY: begin
            if (w_bit_end) w_state_nx = S_STOP1;
         end
         S_STOP1: begin
            // A break is decided on the first stop bit even in two-stop mode.
            if (w_at_s2 && w_brk) begin
               w_state_nx  = S_BRK_WAIT;
               w_frame_end = 1'b1;
               w_brk_end   = 1'b1;
            end else if (w_at_s2 && !r_two_stop) begin
               w_state_nx  = S_IDLE;
               w_frame_end = 1'b1;
            end else if (w_bit_end) begin
               w_state_nx  = S_STOP2;
            end
         end
         S_STOP2: begin
            if (w_at_s2) begin
               w_state_nx  = S_IDLE;
               w_frame_end = 1'b1;
            end
         end
         S_BRK_WAIT: begin
            if (r_cnt >= r_div) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Bit timing, sampling, shift register and error accumulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div        <= 16'd0;
         r_last       <= 3'd0;
         r_par_en     <= 1'b0;
         r_par_odd    <= 1'b0;
         r_two_stop   <= 1'b0;
         r_cnt        <= 16'd0;
         r_s0         <= 1'b1;
         r_s1         <= 1'b1;
         r_bitcnt     <= 3'd0;
         r_data       <= 8'h00;
         r_par_bit    <= 1'b0;
         r_ferr       <= 1'b0;
         r_push_pend  <= 1'b0;
         r_push_entry <= 11'd0;
      end else begin
         r_push_pend <= w_frame_end;
         if (w_frame_end)
            r_push_entry <= w_brk_end ? {2'b11, w_perr, 8'h00}
                                      : {1'b0, r_ferr | ~w_maj, w_perr, r_data};
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_div      <= clkdiv;
                  r_last     <= {1'b1, data_bits};
                  r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                  r_par_odd  <= (parity_mode == 2'b01);
                  r_two_stop <= two_stop;
                  r_cnt      <= 16'd1;
                  r_bitcnt   <= 3'd0;
                  r_data     <= 8'h00;
                  r_par_bit  <= 1'b0;
                  r_ferr     <= 1'b0;
               end
            end
            S_BRK_WAIT: begin
               // Counts consecutive idle-high cycles; any low restarts the wait.
               r_cnt <= w_rxs ? r_cnt + 16'd1 : 16'd0;
            end
            default: begin
               r_cnt <= w_bit_end ? 16'd1 : r_cnt + 16'd1;
               if (w_at_s0) r_s0 <= w_rxs;
               if (w_at_s1) r_s1 <= w_rxs;
               if (w_at_s2) begin
                  if (r_state == S_DATA)   r_data[r_bitcnt] <= w_maj;
                  if (r_state == S_PARITY) r_par_bit <= w_maj;
                  if (((r_state == S_STOP1) || (r_state == S_STOP2)) && !w_maj)
                     r_ferr <= 1'b1;
               end
               if ((r_state == S_DATA) && w_bit_end) r_bitcnt <= r_bitcnt + 3'd1;
               if (w_brk_end) r_cnt <= 16'd0;
            end
         endcase
      end
   end

   assign w_full = (r_count == L_DEPTH);
   assign w_pop  = o_tvalid & o_tready;
   // A full FIFO drops the frame even if a pop happens in the same cycle.
   assign w_push = r_push_pend & ~w_full;
   assign w_drop = r_push_pend & w_full;

   // FIFO storage; contents are only visible through the valid-gated head.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= r_push_entry;
   end

   // FIFO pointers, occupancy and overrun counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ovr   <= 16'd0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (clear_overrun)                     r_ovr <= 16'd0;
         else if (w_drop && (r_ovr != 16'hFFFF)) r_ovr <= r_ovr + 16'd1;
      end
   end

   assign w_head        = r_mem[r_rd];
   assign o_tvalid      = (r_count != '0);
   assign o_tdata       = o_tvalid ? w_head[7:0]  : 8'h00;
   assign o_tuser       = o_tvalid ? w_head[10:8] : 3'b000;
   assign fifo_level    = 16'(r_count);
   assign overrun_count = r_ovr;

endmodule

// File: tb/tb_axi_uart_rx_ext.sv
// Self-checking bench for axi_uart_rx_ext: directed frames from the test plan
// followed by randomized frame formats, against a frame-level reference model.
module tb_axi_uart_rx_ext;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, rx, two_stop, o_tvalid, o_tready, clear_overrun;
   logic [15:0] clkdiv, fifo_level, overrun_count;
   logic [1:0]  data_bits, parity_mode;
   logic [7:0]  o_tdata;
   logic [2:0]  o_tuser;

   int          checks   = 0;
   int          failures = 0;
   logic [10:0] exp_q[$];
   int          exp_ovr  = 0;

   always #5 clk = ~clk;

   axi_uart_rx_ext #(.SIZE(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .rx(rx), .clkdiv(clkdiv), .data_bits(data_bits),
      .parity_mode(parity_mode), .two_stop(two_stop), .o_tdata(o_tdata),
      .o_tuser(o_tuser), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .fifo_level(fifo_level), .overrun_count(overrun_count),
      .clear_overrun(clear_overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Expected FIFO entry {break, frame_err, parity_err, data} for one frame.
   function automatic logic [10:0] model_entry(input logic [7:0] dm, input logic [1:0] db,
         input logic [1:0] pm, input logic pbit, input logic ts, input logic s1, input logic s2);
      logic par_en, perr, ferr, brk;
      int   ones;
      par_en = (pm == 2'b01) || (pm == 2'b10);
      ones   = $countones(dm) + ((par_en && pbit) ? 1 : 0);
      perr   = par_en && ((pm == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1));
      ferr   = !s1 || (ts && !s2);
      brk    = (dm == 8'h00) && !(par_en && pbit) && !s1;
      if (brk) return {2'b11, perr, 8'h00};
      return {1'b0, ferr, perr, dm};
   endfunction

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear_overrun = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
      exp_ovr = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
         input logic ts, input int div, input logic pflip, input logic s1, input logic s2,
         input logic glitch, input logic scramble);
      int n;
      logic [7:0] dm, sh;
      logic par_en, pbit;
      n      = 5 + int'(db);
      dm     = d & (8'hFF >> (8 - n));
      par_en = (pm == 2'b01) || (pm == 2'b10);
      pbit   = ((pm == 2'b01) ? ~(^dm) : (^dm)) ^ pflip;
      clkdiv = 16'(div); data_bits = db; parity_mode = pm; two_stop = ts;
      rx = 1'b0;
      repeat (div) @(negedge clk);
      if (scramble) begin
         clkdiv      = 16'($urandom_range(0, 40));
         data_bits   = 2'($urandom);
         parity_mode = 2'($urandom);
         two_stop    = 1'($urandom);
      end
      sh = dm;
      for (int i = 0; i < n; i++) begin
         rx = sh[0];
         sh = sh >> 1;
         repeat (div) @(negedge clk);
      end
      if (par_en) begin
         rx = pbit;
         repeat (div) @(negedge clk);
      end
      rx = s1;
      if (glitch) begin
         repeat (div / 2) @(negedge clk);
         rx = 1'b0;
         @(negedge clk);
         rx = s1;
         repeat (div - div / 2 - 1) @(negedge clk);
      end else begin
         repeat (div) @(negedge clk);
      end
      if (ts) begin
         rx = s2;
         repeat (div) @(negedge clk);
      end
      rx = 1'b1;
      if (div >= 4) begin
         if (exp_q.size() < DEPTH)
            exp_q.push_back(model_entry(dm, db, pm, par_en ? pbit : 1'b0, ts, s1, s2));
         else if (exp_ovr < 65535)
            exp_ovr++;
      end
   endtask

   task automatic drain(input string tag);
      logic [10:0] e;
      int k;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         k = 0;
         while (!o_tvalid && k < 100) begin
            @(negedge clk);
            k++;
         end
         check({tag, "_valid"}, 32'(o_tvalid), 32'd1);
         check({tag, "_tdata"}, 32'(o_tdata), 32'(e[7:0]));
         check({tag, "_tuser"}, 32'(o_tuser), 32'(e[10:8]));
         o_tready = 1'b1;
         @(negedge clk);
         o_tready = 1'b0;
      end
      repeat (2) @(negedge clk);
      check({tag, "_empty"}, 32'(fifo_level), 32'd0);
   endtask

   initial begin
      int nf, div;
      logic [7:0] d;
      logic [1:0] db, pm;
      logic ts, pf, s1, s2, gl;

      rst = 1'b0; rx = 1'b1; clkdiv = 16'd16; data_bits = 2'b11; parity_mode = 2'b00;
      two_stop = 1'b0; o_tready = 1'b0; clear_overrun = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", 32'(o_tvalid), 32'd0);
      check("rst_level",  32'(fifo_level), 32'd0);
      check("rst_ovr",    32'(overrun_count), 32'd0);
      check("rst_tdata",  32'(o_tdata), 32'd0);
      check("rst_tuser",  32'(o_tuser), 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 back-to-back frames with no idle gap
      send(8'hA5, 2'b11, 2'b00, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'h3C, 2'b11, 2'b00, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("b2b_level", 32'(fifo_level), 32'd2);
      drain("b2b");

      // 7E2 with good and flipped parity
      send(8'h55, 2'b10, 2'b10, 1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'h55, 2'b10, 2'b10, 1'b1, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drain("7e2");

      // 5O1 at clkdiv 20: bad stop bit, then a glitched but valid stop bit
      send(8'h1F, 2'b00, 2'b01, 1'b0, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(44);
      send(8'h1F, 2'b00, 2'b01, 1'b0, 20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      drain("5o1");

      // False start: short low pulse on an idle 8N1 line
      clkdiv = 16'd16; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(60);
      check("fstart_level", 32'(fifo_level), 32'd0);
      check("fstart_valid", 32'(o_tvalid), 32'd0);

      // Break: 12 bit-times low, then low again before a full idle bit time
      rx = 1'b0;
      repeat (12 * 16) @(negedge clk);
      check("brk_level_low", 32'(fifo_level), 32'd1);
      idle(8);
      rx = 1'b0;
      repeat (10 * 16) @(negedge clk);
      idle(40);
      check("brk_level_wait", 32'(fifo_level), 32'd1);
      exp_q.push_back(model_entry(8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      send(8'h5A, 2'b11, 2'b00, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drain("brk");

      // Illegal clkdiv holds the receiver idle
      send(8'h96, 2'b11, 2'b00, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(30);
      check("div3_level", 32'(fifo_level), 32'd0);

      // Overrun: six frames into a four-entry FIFO
      for (int f = 0; f < 6; f++)
         send(8'($urandom), 2'b11, 2'b00, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("ovr_level", 32'(fifo_level), 32'd4);
      check("ovr_count", 32'(overrun_count), 32'(exp_ovr));
      check("ovr_count2", 32'(overrun_count), 32'd2);
      pulse_clear();
      check("ovr_clear", 32'(overrun_count), 32'd0);
      drain("ovr");

      // Randomized formats with mid-frame configuration scrambling
      for (int b = 0; b < 6; b++) begin
         nf = $urandom_range(1, 6);
         for (int f = 0; f < nf; f++) begin
            db  = 2'($urandom);
            pm  = 2'($urandom);
            ts  = 1'($urandom);
            div = $urandom_range(4, 20);
            d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pf  = ($urandom_range(0, 3) == 0);
            s1  = ($urandom_range(0, 3) != 0);
            s2  = ($urandom_range(0, 3) != 0);
            gl  = s1 && ($urandom_range(0, 2) == 0);
            send(d, db, pm, ts, div, pf, s1, s2, gl, 1'b1);
            if (!s1 || (ts && !s2)) idle(2 * div + 4);
            else                    idle($urandom_range(0, 3));
         end
         check("rnd_ovr", 32'(overrun_count), 32'(exp_ovr));
         pulse_clear();
         drain("rnd");
      end

      // Reset in the middle of the data bits
      send(8'hC3, 2'b11, 2'b00, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      clkdiv = 16'd16; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mrst_tvalid", 32'(o_tvalid), 32'd0);
      check("mrst_level",  32'(fifo_level), 32'd0);
      check("mrst_tdata",  32'(o_tdata), 32'd0);
      check("mrst_tuser",  32'(o_tuser), 32'd0);
      check("mrst_ovr",    32'(overrun_count), 32'd0);
      idle(5);
      rst = 1'b1;
      exp_q.delete();
      idle(20);
      send(8'h81, 2'b11, 2'b00, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drain("mrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
